// File: rtl/rst_seq_ctrl.sv
// Staged reset release to NUM_DOM domains after chip reset, soft-reset request or watchdog trip.
// Optional watchdog restart enabled by defining RST_WDOG_EN (adds wdog_kick port).
module rst_seq_ctrl #(
   parameter int NUM_DOM  = 3,
   parameter int NUM_REQ  = 2,
   parameter int HOLD_CYC = 16,
   parameter int WDOG_CYC = 4096
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 soft_req,
`ifdef RST_WDOG_EN
   input  logic                               wdog_kick,
`endif
   output logic [NUM_REQ-1:0]                 soft_ack,
   output logic [NUM_DOM-1:0]                 dom_rst_n,
   output logic                               seq_busy,
   output logic                               seq_done,
   output logic [$clog2(NUM_REQ+2)-1:0]       last_src
);

   localparam int SW = $clog2(NUM_REQ + 2);
   localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYC - 1);
   localparam logic [IW-1:0] DOM_LAST  = IW'(NUM_DOM - 1);

   typedef enum logic [1:0] {ST_HOLD, ST_REL, ST_IDLE} state_e;

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [NUM_DOM-1:0] dom_q, dom_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [SW-1:0]      src_q, src_d;
   // run_q holds off counting on the first edge after rst_n so that edge acts as E0
   logic               run_q, run_d;

   logic               req_any;
   logic [RW-1:0]      win;
   logic               wdog_trip;

   always_comb begin
      win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (soft_req[i]) win = RW'(i);
      end
   end

   assign req_any = |soft_req;

`ifdef RST_WDOG_EN
   logic [15:0] wcnt_q, wcnt_d;

   assign wdog_trip = (wcnt_q == 16'(WDOG_CYC - 1)) && !wdog_kick;

   always_comb begin
      wcnt_d = '0;
      if (state_q == ST_IDLE && !req_any && !wdog_trip && !wdog_kick) wcnt_d = wcnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) wcnt_q <= '0;
      else        wcnt_q <= wcnt_d;
   end
`else
   assign wdog_trip = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ack_d   = '0;
      src_d   = src_q;
      run_d   = 1'b1;
      case (state_q)
         ST_HOLD, ST_REL: begin
            if (run_q) begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d        = '0;
                  dom_d[idx_q] = 1'b1;
                  if (idx_q == DOM_LAST) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     idx_d   = '0;
                  end else begin
                     state_d = ST_REL;
                     idx_d   = idx_q + IW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            if (req_any || wdog_trip) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               idx_d   = '0;
               dom_d   = '0;
               busy_d  = 1'b1;
               if (req_any) begin
                  ack_d[win] = 1'b1;
                  src_d      = SW'(win) + SW'(1);
               end else begin
                  src_d = SW'(NUM_REQ + 1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         ack_q   <= '0;
         src_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ack_q   <= ack_d;
         src_q   <= src_d;
         run_q   <= run_d;
      end
   end

   assign dom_rst_n = dom_q;
   assign seq_busy  = busy_q;
   assign seq_done  = done_q;
   assign soft_ack  = ack_q;
   assign last_src  = src_q;

endmodule
